pc_reg: RTL and testbench

Program-counter register for the nanosoc core fetch stage.
- Holds the current instruction address and drives it to instruction fetch.
- Advances the address by 4 every clock.
- Loads an absolute target when the execute stage asserts a jump.

---
 rtl/nanosoc_pkg.sv | 18 +
 rtl/pc_reg.sv | 55 +++++
 tb/tb_pc_reg.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/nanosoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nanosoc_pkg
// Brief    : Shared address-width, reset-vector and PC-step constants
//            for the nanosoc core.
// Revision : 1.0 - initial release
// ============================================================================
package nanosoc_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [31:0] addr_t;

  localparam addr_t       RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned PC_STEP      = 4;

endpackage : nanosoc_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Brief    : Fetch-stage program counter. It advances by PC_INCR each cycle
//            and loads an absolute target on jump. Optional stall input is
//            enabled with the macro PC_REG_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_reg
  import nanosoc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = nanosoc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VECTOR),
  parameter int unsigned       PC_INCR    = PC_STEP
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
`ifdef PC_REG_HOLD_EN
  input  logic              hold_i,
`endif
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] C_INCR = ADDR_W'(PC_INCR);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;

  // An X/Z jump flag must fall through to increment, so only an explicit 1 jumps.
  always_comb begin
    w_pc_next = r_pc + C_INCR;
    if (jump_flag_i == 1'b1) begin
      w_pc_next = jump_addr_i;
    end
`ifdef PC_REG_HOLD_EN
    else if (hold_i == 1'b1) begin
      w_pc_next = r_pc;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pc <= RESET_ADDR;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc_o = r_pc;

endmodule : pc_reg
`default_nettype wire

// File: tb/tb_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_reg
// Brief    : Randomized scoreboard bench for pc_reg (honours PC_REG_HOLD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_reg;
  import nanosoc_pkg::*;

  localparam addr_t RST = RESET_VECTOR;

  logic  clk         = 1'b0;
  logic  rst_        = 1'b0;
  logic  jump_flag_i = 1'b0;
  addr_t jump_addr_i = '0;
  logic  hold_i      = 1'b0;
  addr_t pc_o;

  logic  release_req = 1'b0;
  int    total = 0;
  int    bad   = 0;
  addr_t exp_pc = RST;
  addr_t exp_q[$];

  pc_reg dut (
    .clk         (clk),
    .rst_        (rst_),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
`ifdef PC_REG_HOLD_EN
    .hold_i      (hold_i),
`endif
    .pc_o        (pc_o)
  );

  // Reset release is applied just ahead of the rising edge in the same time
  // step, so the edge deterministically sees rst_=1 (coincident release).
  initial begin
    forever begin
      #5;
      if (!clk && release_req) begin
        rst_        = 1'b1;
        release_req = 1'b0;
      end
      clk = ~clk;
    end
  end

  task automatic check(input string name, input addr_t act, input addr_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: pc_o=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next PC from the architectural rules.
  always @(posedge clk) begin
    if (rst_ !== 1'b1)              exp_pc = RST;
    else if (jump_flag_i === 1'b1)  exp_pc = jump_addr_i;
    else if (hold_i === 1'b1)       exp_pc = exp_pc;
    else                            exp_pc = exp_pc + PC_STEP;
    exp_q.push_back(exp_pc);
  end

  always @(negedge rst_) exp_pc = RST;

  // Monitor: the PC is a new output every cycle.
  always @(posedge clk) begin
    addr_t e;
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: pc_o=%h expected=<none>", pc_o);
    end else begin
      e = exp_q.pop_front();
      check("sb", pc_o, e);
    end
  end

  task automatic drive(input logic jf, input addr_t ja, input logic h);
    jump_flag_i = jf;
    jump_addr_i = ja;
`ifdef PC_REG_HOLD_EN
    hold_i = h;
`else
    hold_i = 1'b0 & h;
`endif
    @(negedge clk);
  endtask

  // Called at a falling edge: reset mid-cycle, check, then release on an edge.
  task automatic async_reset();
    #2 rst_ = 1'b0;
    #1 check("mid_cycle_reset", pc_o, RST);
    @(negedge clk);
    release_req = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: pc_o=%h expected=finish", pc_o);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 check("reset_async", pc_o, RST);
    repeat (3) @(negedge clk);
    release_req = 1'b1;
    @(negedge clk);

    #2 rst_ = 1'b0;
    #1 check("mid_cycle_reset", pc_o, RST);
    @(negedge clk);
    release_req = 1'b1;
    repeat (3) @(negedge clk);

    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);

    drive(1'b1, 32'hFFFF_FFFC, 1'b0);
    drive(1'b0, 32'h0, 1'b0);

    drive(1'b1, 32'h0000_0100, 1'b0);
    drive(1'b1, 32'h0000_0200, 1'b0);
    drive(1'b1, 32'h0000_0300, 1'b0);
    drive(1'b0, 32'h0, 1'b0);

    jump_flag_i = 1'bx;
    repeat (2) @(negedge clk);
    jump_flag_i = 1'b0;

`ifdef PC_REG_HOLD_EN
    drive(1'b1, 32'h0000_0008, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h0000_0040, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset();
      end else begin
        drive(($urandom_range(0, 3) == 0), addr_t'($urandom),
              ($urandom_range(0, 3) == 0));
      end
    end
    drive(1'b0, 32'h0, 1'b0);

    check("sb_drain", addr_t'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_reg
`default_nettype wire
